// File: rtl/piano_pkg.sv
// piano_pkg: shared widths and the 100 MHz half-period table for the 16 chromatic notes
package piano_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int N_NOTES = 16;
  localparam int CNT_W = 18;
  function automatic logic [CNT_W-1:0] half_period(input logic [3:0] n);
    case (n)
      4'd0: half_period = 18'd191113;
      4'd1: half_period = 18'd180388;
      4'd2: half_period = 18'd170265;
      4'd3: half_period = 18'd160705;
      4'd4: half_period = 18'd151685;
      4'd5: half_period = 18'd143172;
      4'd6: half_period = 18'd135139;
      4'd7: half_period = 18'd127551;
      4'd8: half_period = 18'd120395;
      4'd9: half_period = 18'd113636;
      4'd10: half_period = 18'd107259;
      4'd11: half_period = 18'd101239;
      4'd12: half_period = 18'd95557;
      4'd13: half_period = 18'd90193;
      4'd14: half_period = 18'd85131;
      default: half_period = 18'd80354;
    endcase
  endfunction
endpackage

// File: rtl/piano_if.sv
// piano_if: control inputs and speaker output of the tone generator
interface piano_if;
  logic hush;
  logic [3:0] note;
  logic speaker;
  modport master (output hush, output note, input speaker);
  modport slave (input hush, input note, output speaker);
endinterface

// File: rtl/piano_note_rom.sv
// piano_note_rom: combinational note index to half-period lookup
module piano_note_rom
  import piano_pkg::*;
(
  input  logic [3:0]       note,
  output logic [CNT_W-1:0] half
);
  assign half = half_period(note);
endmodule

// File: rtl/piano_core.sv
// piano_core: square-wave tone generator with synchronised hush/note inputs
module piano_core
  import piano_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic    clk,
  input logic    rst,
  piano_if.slave io
);
  logic [SYNC_STAGES-1:0] hush_sr;
  logic [SYNC_STAGES-1:0][3:0] note_sr;
  logic hush_s;
  logic [3:0] note_s;
  logic [3:0] note_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half;
  logic spk;
  logic spk_d;
  logic chg;
  logic last;
  piano_note_rom rom (.note(note_s), .half(half));
  assign hush_s = hush_sr[SYNC_STAGES-1];
  assign note_s = note_sr[SYNC_STAGES-1];
  assign io.speaker = spk;
  always_comb begin
    chg = note_s != note_q;
    last = cnt == half - CNT_W'(1);
    cnt_d = (hush_s || chg || last) ? '0 : cnt + CNT_W'(1);
    // a note change restarts the count but keeps the current speaker level
    spk_d = hush_s ? 1'b0 : (!chg && last) ? ~spk : spk;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hush_sr <= '0;
      note_sr <= '0;
      note_q <= '0;
      cnt <= '0;
      spk <= 1'b0;
    end else begin
      hush_sr <= {hush_sr[SYNC_STAGES-2:0], io.hush};
      note_sr <= {note_sr[SYNC_STAGES-2:0], io.note};
      note_q <= note_s;
      cnt <= cnt_d;
      spk <= spk_d;
    end
  end
endmodule

// File: tb/tb_piano_core.sv
// tb_piano_core: random stimulus against a segment/elapsed-time model, with counter preloads to reach toggles quickly
module tb_piano_core;
  import piano_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  piano_if pif ();
  piano_core dut (.clk(clk), .rst(rst), .io(pif));
  int total = 0;
  int bad = 0;
  int hp[16] = '{191113, 180388, 170265, 160705, 151685, 143172, 135139, 127551,
                 120395, 113636, 107259, 101239, 95557, 90193, 85131, 80354};
  logic hd[2];
  logic [3:0] nd[2];
  logic [3:0] m_nq;
  logic m_base;
  logic m_spk;
  int m_el;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  // speaker = base level flipped once per elapsed half-period since the last restart
  initial forever begin
    logic hs;
    logic [3:0] ns;
    @(posedge clk);
    if (rst) begin
      hd = '{1'b0, 1'b0};
      nd = '{4'd0, 4'd0};
      m_nq = 4'd0;
      m_base = 1'b0;
      m_el = 0;
      m_spk = 1'b0;
    end else begin
      hs = hd[1];
      ns = nd[1];
      if (hs) begin
        m_base = 1'b0;
        m_el = 0;
      end else if (ns != m_nq) begin
        m_base = m_spk;
        m_el = 0;
      end else m_el++;
      m_spk = m_base ^ (((m_el / hp[ns]) % 2) == 1);
      m_nq = ns;
      hd[1] = hd[0];
      hd[0] = pif.hush;
      nd[1] = nd[0];
      nd[0] = pif.note;
    end
  end
  initial forever begin
    @(negedge clk);
    chk("speaker_vs_model", {31'd0, pif.speaker}, {31'd0, m_spk});
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  // jump the counter forward; the model's elapsed time jumps by the same amount
  task automatic preload(input int v);
    logic [CNT_W-1:0] v18;
    v18 = CNT_W'(v);
    force dut.cnt = v18;
    release dut.cnt;
    m_el = m_el - (m_el % hp[m_nq]) + v;
  endtask
  initial begin
    pif.hush = 1'b0;
    pif.note = 4'd9;
    rst = 1'b1;
    cyc(3);
    chk("reset_speaker", {31'd0, pif.speaker}, 32'd0);
    rst = 1'b0;
    cyc(10);
    chk("post_reset_silent", {31'd0, pif.speaker}, 32'd0);
    preload(113636 - 5);
    cyc(4);
    chk("before_first_rise", {31'd0, pif.speaker}, 32'd0);
    cyc(1);
    chk("first_rise", {31'd0, pif.speaker}, 32'd1);
    pif.hush = 1'b1;
    cyc(2);
    chk("hush_not_yet", {31'd0, pif.speaker}, 32'd1);
    cyc(1);
    chk("hush_forces_low", {31'd0, pif.speaker}, 32'd0);
    cyc(5);
    chk("hush_held_low", {31'd0, pif.speaker}, 32'd0);
    pif.hush = 1'b0;
    cyc(2);
    preload(113636 - 3);
    cyc(2);
    chk("release_before_rise", {31'd0, pif.speaker}, 32'd0);
    cyc(1);
    chk("release_rise", {31'd0, pif.speaker}, 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("rst_mid_tone", {31'd0, pif.speaker}, 32'd0);
    rst = 1'b0;
    pif.note = 4'd0;
    cyc(5);
    preload(191100);
    pif.note = 4'd15;
    cyc(40);
    chk("no_old_note_toggle", {31'd0, pif.speaker}, 32'd0);
    preload(80354 - 2);
    cyc(1);
    chk("new_note_before", {31'd0, pif.speaker}, 32'd0);
    cyc(1);
    chk("new_note_toggle", {31'd0, pif.speaker}, 32'd1);
    for (int n = 0; n < 16; n++) begin
      pif.note = 4'(n);
      cyc(3);
      chk($sformatf("rom_note%0d", n), 32'(dut.half), 32'(hp[n]));
    end
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: pif.note = 4'($urandom_range(0, 15));
        1: pif.hush = ($urandom_range(0, 3) == 0);
        default: preload(hp[m_nq] - 1 - int'($urandom_range(0, 30)));
      endcase
      cyc($urandom_range(1, 40));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
